// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types, constants and the active-low hex glyph table for the scan controller.
package seven_seg_pkg;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Glyph bits are {g,f,e,d,c,b,a}, 0 = segment lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_tick_gen.sv
// seven_seg_tick_gen: per-slot prescaler; strobes the last dead-time cycle and the slot end, frozen while enable=0.
module seven_seg_tick_gen #(
    parameter int TICK_DIV = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic clock,
    input  logic nReset,
    input  logic enable,
    output logic slot_end,
    output logic dead_end
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count;

    assign slot_end = enable && count == CW'(TICK_DIV - 1);
    assign dead_end = enable && count == CW'(DEAD_CYC - 1);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) count <= '0;
        else if (slot_end) count <= '0;
        else if (enable) count <= count + 1'b1;
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed common-anode 7-seg scanner with frame-synchronous double buffer.
// Optional leading-zero suppression when SEVEN_SEG_LZ_BLANK_EN is defined.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int DEAD_CYC   = 16
) (
    input  logic                    clock,
    input  logic                    nReset,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic                    slot_end, dead_end, last, wrap, show, full;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow, active;
    logic [NUM_DIGITS-1:0]   lz;
    scan_state_t             state, state_nxt;

    seven_seg_tick_gen #(.TICK_DIV(TICK_DIV), .DEAD_CYC(DEAD_CYC)) u_tick (
        .clock   (clock),
        .nReset  (nReset),
        .enable  (enable),
        .slot_end(slot_end),
        .dead_end(dead_end)
    );

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every nibble above it are zero.
    always_comb begin
        lz = '0;
        for (int i = 1; i < NUM_DIGITS; i++) lz[i] = (active >> (4 * i)) == '0;
    end
`else
    assign lz = '0;
`endif

    assign last       = idx == IW'(NUM_DIGITS - 1);
    assign wrap       = slot_end && last;
    assign show       = state == DRIVE && !lz[idx];
    assign load_ready = !full;

    always_comb begin
        state_nxt = (state == BLANK && dead_end) ? DRIVE :
                    (state == DRIVE && slot_end) ? BLANK : state;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state <= BLANK;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= slot_end ? (last ? '0 : idx + 1'b1) : idx;
        end
    end

    // The shadow cannot accept while full, so commit and transfer never collide.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            shadow <= '0;
            active <= '0;
            full   <= 1'b0;
        end else if (wrap && full) begin
            active <= shadow;
            full   <= 1'b0;
        end else if (load_valid && !full) begin
            shadow <= load_value;
            full   <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            anode      <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            anode      <= (enable && show) ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg        <= (enable && show) ? hex_to_seg(active[4*idx +: 4]) : SEG_OFF;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed scoreboard bench for seven_seg_scan_ctrl (NUM_DIGITS=4, TICK_DIV=8, DEAD_CYC=2).
module tb_seven_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int TD = 8;
    localparam int DC = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sg;
    } exp_t;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = '0;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        frame_done;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .DEAD_CYC(DC)) dut (
        .clock     (clock),
        .nReset    (nReset),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .seg       (seg),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h5: return 7'h12;
            4'h4: return 7'h19;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [3:0] an, input logic [3:0] h);
        sb.push_back('{an, glyph(h)});
    endtask

    task automatic load(input logic [15:0] v);
        load_value = v;
        load_valid = 1'b1;
        cyc(1);
        load_valid = 1'b0;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("frame_done_seen", frame_done, 1'b1);
    endtask

    // Waits for the next digit-on run and scores anode, glyph and run length.
    task automatic run();
        int   k, len;
        exp_t e, g;
        k = 0;
        while (anode !== 4'hF && k < 64) begin cyc(1); k++; end
        while (anode === 4'hF && k < 64) begin cyc(1); k++; end
        g = '{anode, seg};
        len = 0;
        while (anode === g.an && k < 64) begin cyc(1); k++; len++; end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("run_anode", g.an, e.an);
        chk("run_seg", g.sg, e.sg);
        chk("run_len", len, TD - DC);
    endtask

    initial begin
        int  n;
        logic ok;
        enable = 1'b1;
        cyc(2);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_anode", anode, 4'hF);
        chk("reset_ready", load_ready, 1'b1);
        chk("reset_fd", frame_done, 1'b0);
        nReset = 1'b1;

        load(16'h1234);
        chk("ready_low_after_load", load_ready, 1'b0);
        wait_fd();
        chk("ready_after_commit", load_ready, 1'b1);
        push(4'hE, 4'h4); push(4'hD, 4'h3); push(4'hB, 4'h2); push(4'h7, 4'h1);
        repeat (4) run();

        wait_fd();
        n = 0;
        do begin cyc(1); n++; end while (frame_done !== 1'b1 && n < 100);
        chk("frame_period", n, 4 * TD);

        push(4'hE, 4'h4); push(4'hD, 4'h3);
        run(); run();
        load(16'hABCD);
        chk("ready_low_mid_frame", load_ready, 1'b0);
        push(4'hB, 4'h2);
        run();
        load(16'h5555);
        chk("ready_low_backpressure", load_ready, 1'b0);
        push(4'h7, 4'h1);
        run();
        chk("ready_high_after_frame", load_ready, 1'b1);
        push(4'hE, 4'hD); push(4'hD, 4'hC); push(4'hB, 4'hB); push(4'h7, 4'hA);
        repeat (4) run();

        n = 0;
        while (anode === 4'hF && n < 64) begin cyc(1); n++; end
        cyc(2);
        enable = 1'b0;
        cyc(1);
        chk("dark_anode", anode, 4'hF);
        chk("dark_seg", seg, 7'h7F);
        ok = 1'b1;
        repeat (19) begin
            cyc(1);
            ok &= (anode === 4'hF) && (seg === 7'h7F) && (frame_done === 1'b0);
        end
        chk("dark_hold", ok, 1'b1);
        enable = 1'b1;
        cyc(1);
        chk("resume_anode", anode, 4'hE);
        chk("resume_seg", seg, 7'h21);
        n = 0;
        while (anode === 4'hE && n < 20) begin n++; cyc(1); end
        chk("resume_len", n, 3);
        push(4'hD, 4'hC);
        run();

        load(16'h1111);
        chk("ready_low_before_reset", load_ready, 1'b0);
        n = 0;
        while (anode === 4'hF && n < 64) begin cyc(1); n++; end
        nReset = 1'b0;
        #1;
        chk("async_reset_seg", seg, 7'h7F);
        chk("async_reset_anode", anode, 4'hF);
        chk("async_reset_ready", load_ready, 1'b1);
        cyc(2);
        nReset = 1'b1;
        wait_fd();
        push(4'hE, 4'h0);
        run();

        load(16'h0050);
        wait_fd();
`ifdef SEVEN_SEG_LZ_BLANK_EN
        push(4'hE, 4'h0); push(4'hD, 4'h5); push(4'hE, 4'h0);
        repeat (3) run();
`else
        push(4'hE, 4'h0); push(4'hD, 4'h5); push(4'hB, 4'h0); push(4'h7, 4'h0);
        repeat (4) run();
`endif
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
